audio_i2s_master: RTL and testbench
===================================

AUDIO_I2S_MASTER -- requirements
Module: audio_i2s_master

Interface
REQ-001 SHALL have parameter BCK_DIV, default 6, meaning the AUD_BCK half-period in iCLK cycles; legal range 2..255.
REQ-002 SHALL have port iCLK, input, 1 bit: the single system clock, nominally 18.432 MHz.
REQ-003 SHALL have port iRST_N, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port iDAC_L, input, 16 bits: left playback sample, two's complement.
REQ-005 SHALL have port iDAC_R, input, 16 bits: right playback sample.
REQ-006 SHALL have port iDAC_WE, input, 1 bit: writes iDAC_L/iDAC_R into the shadow register.
REQ-007 SHALL have port oSAMPLE_REQ, output, 1 bit: one-cycle pulse meaning the shadow was consumed.
REQ-008 SHALL have port oADC_L, output, 16 bits: last captured left sample.
REQ-009 SHALL have port oADC_R, output, 16 bits: last captured right sample.
REQ-010 SHALL have port oADC_VALID, output, 1 bit: one-cycle pulse meaning oADC_L/oADC_R are updated.
REQ-011 SHALL have port AUD_BCK, output, 1 bit: bit clock to the codec.
REQ-012 SHALL have port AUD_LRCK, output, 1 bit: frame clock; high = left.
REQ-013 SHALL have port AUD_DACDAT, output, 1 bit: serial playback data.
REQ-014 SHALL have port AUD_ADCDAT, input, 1 bit: serial capture data.

Function
REQ-015 SHALL clock every register on the rising edge of iCLK; all outputs SHALL be registered.
REQ-016 SHALL toggle AUD_BCK once every BCK_DIV iCLK cycles, using a divider counter 0..BCK_DIV-1.
REQ-017 SHALL run a 5-bit bit counter that advances on each AUD_BCK 1->0 transition and wraps from 31 to 0; one frame is 32 BCK periods (64*BCK_DIV iCLK cycles).
REQ-018 SHALL drive AUD_LRCK = NOT counter[4]: bits 0..15 are left (high) and bits 16..31 are right (low).
REQ-019 SHALL, on each BCK falling transition, drive AUD_DACDAT = active word bit [15 - counter[3:0]], MSB first, using the left word while LRCK is high and the right word while it is low.
REQ-020 SHALL, on each BCK rising transition, shift the effective ADC input into a 32-bit capture shift register (LSB in).
REQ-021 SHALL treat the falling transition into counter 0 as a frame-start event, with these same-cycle actions:
- load the shadow into the active L/R words;
- pulse oSAMPLE_REQ;
- copy the capture shift register to oADC_L ([31:16]) and oADC_R ([15:0]);
- pulse oADC_VALID.
REQ-022 SHALL suppress oADC_VALID, and leave oADC_L/oADC_R unchanged, on the first frame-start after reset.
REQ-023 SHALL, when iDAC_WE coincides with a frame-start, load the old shadow into the active words and store the new write in the shadow for the next frame.
REQ-024 SHALL replay the same shadow contents in every frame until a new iDAC_WE occurs (no underflow flag).
REQ-025 SHALL keep iDAC_WE writes from affecting the active words mid-frame.

Reset
REQ-026 SHALL, while iRST_N=0, hold the following values:
- AUD_BCK=0, AUD_LRCK=0, AUD_DACDAT=0;
- divider=0, bit counter=31;
- shadow, active and capture registers=0;
- oADC_L=oADC_R=0, oSAMPLE_REQ=oADC_VALID=0.
REQ-027 SHALL, on reset assertion mid-frame, abandon the frame immediately and restart from REQ-026 state; no partial oADC_VALID.
REQ-028 SHALL produce the first frame-start 2*BCK_DIV iCLK cycles after reset release, at the first BCK fall.

Configuration
REQ-029 SHALL use macro AUDIO_I2S_LOOPBACK_EN: when defined, the effective ADC input is the internal AUD_DACDAT register and AUD_ADCDAT is ignored.
REQ-030 SHALL, when AUDIO_I2S_LOOPBACK_EN is undefined, take the effective ADC input from AUD_ADCDAT; no loopback logic is present.

Verification
REQ-031 Stimulus: BCK_DIV=2, reset released, no iDAC_WE. Required response: AUD_BCK period 4 cycles; AUD_LRCK period 128 cycles; oSAMPLE_REQ every 128 cycles; first frame-start has no oADC_VALID.
REQ-032 Stimulus: write L=16'hA5C3, R=16'h0F0F before a frame-start. Required response: the following frame shows AUD_DACDAT bits 1010010111000011 during LRCK high, then 0000111100001111 during LRCK low.
REQ-033 Stimulus: AUD_ADCDAT driven with L=16'h8001, R=16'h7FFE, aligned to BCK rising. Required response: at the next frame-start, oADC_VALID=1, oADC_L=16'h8001, oADC_R=16'h7FFE.
REQ-034 Stimulus: iDAC_WE (16'h1111) in the same cycle as a frame-start, shadow previously 16'h2222. Required response: that frame transmits 16'h2222; the next frame transmits 16'h1111.
REQ-035 Stimulus: with AUDIO_I2S_LOOPBACK_EN defined, write L=16'hBEEF, R=16'h1234. Required response: one frame after they become active, oADC_L=16'hBEEF and oADC_R=16'h1234.
REQ-036 Stimulus: iRST_N pulsed low at bit 20 of a frame. Required response: outputs are at reset values immediately; no oADC_VALID occurs for that frame; the first frame-start comes 2*BCK_DIV cycles after release.

Source files
------------

// File: rtl/audio_i2s_master.sv
// audio_i2s_master: I2S codec master with BCK/LRCK generation, shadowed DAC words and ADC capture (option: AUDIO_I2S_LOOPBACK_EN)
module audio_i2s_master #(
    parameter int BCK_DIV = 6
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic [15:0] iDAC_L,
    input  logic [15:0] iDAC_R,
    input  logic        iDAC_WE,
    output logic        oSAMPLE_REQ,
    output logic [15:0] oADC_L,
    output logic [15:0] oADC_R,
    output logic        oADC_VALID,
    output logic        AUD_BCK,
    output logic        AUD_LRCK,
    output logic        AUD_DACDAT,
    input  logic        AUD_ADCDAT
);
    logic [7:0]  div_q, div_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        bck_q, bck_d, lrck_q, lrck_d, dac_q, dac_d;
    logic [15:0] sh_l_q, sh_l_d, sh_r_q, sh_r_d, act_l_q, act_l_d, act_r_q, act_r_d;
    logic [31:0] cap_q, cap_d;
    logic [15:0] adc_l_q, adc_l_d, adc_r_q, adc_r_d;
    logic        req_q, req_d, valid_q, valid_d, seen_q, seen_d;
    logic        tick, rise, fall, fs, adc_in;
    logic [15:0] wl, wr, word;

`ifdef AUDIO_I2S_LOOPBACK_EN
    logic unused_adcdat;
    assign unused_adcdat = AUD_ADCDAT;
    assign adc_in = dac_q;
`else
    assign adc_in = AUD_ADCDAT;
`endif

    // Next-state: BCK divider, bit counter, frame-start actions, serial data in/out
    always_comb begin
        tick      = div_q == 8'(BCK_DIV - 1);
        rise      = tick && !bck_q;
        fall      = tick && bck_q;
        fs        = fall && cnt_q == 5'd31;
        div_d     = tick ? 8'd0 : div_q + 8'd1;
        bck_d     = tick ? ~bck_q : bck_q;
        cnt_d     = fall ? cnt_q + 5'd1 : cnt_q;
        lrck_d    = ~cnt_d[4];
        wl        = fs ? sh_l_q : act_l_q;
        wr        = fs ? sh_r_q : act_r_q;
        word      = cnt_d[4] ? wr : wl;
        dac_d     = fall ? word[4'd15 - cnt_d[3:0]] : dac_q;
        act_l_d   = wl;
        act_r_d   = wr;
        sh_l_d    = iDAC_WE ? iDAC_L : sh_l_q;
        sh_r_d    = iDAC_WE ? iDAC_R : sh_r_q;
        cap_d     = rise ? {cap_q[30:0], adc_in} : cap_q;
        req_d     = fs;
        valid_d   = fs && seen_q;
        seen_d    = seen_q || fs;
        adc_l_d   = valid_d ? cap_q[31:16] : adc_l_q;
        adc_r_d   = valid_d ? cap_q[15:0] : adc_r_q;
    end

    // State registers; reset abandons any frame in progress
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            div_q   <= '0;
            cnt_q   <= 5'd31;
            bck_q   <= 1'b0;
            lrck_q  <= 1'b0;
            dac_q   <= 1'b0;
            sh_l_q  <= '0;
            sh_r_q  <= '0;
            act_l_q <= '0;
            act_r_q <= '0;
            cap_q   <= '0;
            adc_l_q <= '0;
            adc_r_q <= '0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            seen_q  <= 1'b0;
        end else begin
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            bck_q   <= bck_d;
            lrck_q  <= lrck_d;
            dac_q   <= dac_d;
            sh_l_q  <= sh_l_d;
            sh_r_q  <= sh_r_d;
            act_l_q <= act_l_d;
            act_r_q <= act_r_d;
            cap_q   <= cap_d;
            adc_l_q <= adc_l_d;
            adc_r_q <= adc_r_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            seen_q  <= seen_d;
        end
    end

    assign AUD_BCK     = bck_q;
    assign AUD_LRCK    = lrck_q;
    assign AUD_DACDAT  = dac_q;
    assign oSAMPLE_REQ = req_q;
    assign oADC_VALID  = valid_q;
    assign oADC_L      = adc_l_q;
    assign oADC_R      = adc_r_q;
endmodule

// File: tb/tb_audio_i2s_master.sv
// tb_audio_i2s_master: cycle-level reference model check of audio_i2s_master with BCK_DIV=2
module tb_audio_i2s_master;
    localparam int D = 2;
    logic        iCLK = 0, iRST_N = 0, iDAC_WE = 0, AUD_ADCDAT = 0;
    logic [15:0] iDAC_L = 0, iDAC_R = 0;
    logic        oSAMPLE_REQ, oADC_VALID, AUD_BCK, AUD_LRCK, AUD_DACDAT;
    logic [15:0] oADC_L, oADC_R;

    audio_i2s_master #(.BCK_DIV(D)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iDAC_L(iDAC_L), .iDAC_R(iDAC_R), .iDAC_WE(iDAC_WE),
        .oSAMPLE_REQ(oSAMPLE_REQ), .oADC_L(oADC_L), .oADC_R(oADC_R), .oADC_VALID(oADC_VALID),
        .AUD_BCK(AUD_BCK), .AUD_LRCK(AUD_LRCK), .AUD_DACDAT(AUD_DACDAT), .AUD_ADCDAT(AUD_ADCDAT)
    );

    always #5 iCLK = ~iCLK;

    int total = 0, bad = 0, n = 0, cyc = 0;
    logic [15:0] sh_l = 0, sh_r = 0, tx_l = 0, tx_r = 0, al = 0, ar = 0, nal = 0, nar = 0, ex_l = 0, ex_r = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // model: n = edges since reset release; frame f starts at edge 2D + 64D*f
    task automatic step();
        logic fs, eb, el, ed;
        int b;
        @(posedge iCLK);
        cyc++;
        fs = 0;
        if (!iRST_N) begin
            n = 0; sh_l = 0; sh_r = 0; tx_l = 0; tx_r = 0; ex_l = 0; ex_r = 0;
        end else begin
            n++;
            fs = n >= 2*D && (n - 2*D) % (64*D) == 0;
            if (fs) begin
                if (n > 2*D) begin
`ifdef AUDIO_I2S_LOOPBACK_EN
                    ex_l = tx_l; ex_r = tx_r;
`else
                    ex_l = al; ex_r = ar;
`endif
                end
                tx_l = sh_l; tx_r = sh_r; al = nal; ar = nar;
            end
            if (iDAC_WE) begin
                sh_l = iDAC_L; sh_r = iDAC_R;
            end
        end
        b  = (n / (2*D) + 31) % 32;
        eb = ((n / D) % 2) == 1;
        el = b < 16;
        ed = n < 2*D ? 1'b0 : (b < 16 ? tx_l[15-b] : tx_r[31-b]);
        #1;
        chk($sformatf("cycle %0d outputs", cyc),
            {27'd0, AUD_BCK, AUD_LRCK, AUD_DACDAT, oSAMPLE_REQ, oADC_VALID, oADC_L, oADC_R},
            {27'd0, eb, el, ed, fs, fs && n > 2*D, ex_l, ex_r});
        AUD_ADCDAT = b < 16 ? al[15-b] : ar[31-b];
    endtask

    task automatic write(input logic [15:0] l, input logic [15:0] r);
        iDAC_L = l; iDAC_R = r; iDAC_WE = 1;
        step();
        iDAC_WE = 0;
    endtask

    task automatic wait_req(output int t);
        bit found = 0;
        for (int k = 0; k < 300 && !found; k++) begin
            step();
            found = oSAMPLE_REQ;
        end
        if (!found) chk("sample_req timeout", 0, 1);
        t = cyc;
    endtask

    task automatic wait_rise(input bit lr, output int t);
        logic p, c;
        bit found = 0;
        p = lr ? AUD_LRCK : AUD_BCK;
        for (int k = 0; k < 300 && !found; k++) begin
            step();
            c = lr ? AUD_LRCK : AUD_BCK;
            found = !p && c;
            p = c;
        end
        if (!found) chk("clock rise timeout", 0, 1);
        t = cyc;
    endtask

    task automatic collect(input bit wait_first, output logic [31:0] w);
        int t;
        if (wait_first) wait_req(t);
        w[31] = AUD_DACDAT;
        for (int k = 1; k < 32; k++) begin
            repeat (2*D) step();
            w[31-k] = AUD_DACDAT;
        end
    endtask

    initial begin
        int rel, t1, t2;
        logic [31:0] w;
        repeat (3) step();
        iRST_N = 1;
        rel = cyc;
        wait_req(t1);
        chk("first frame-start delay", 64'(t1 - rel), 4);
        chk("first frame-start no valid", oADC_VALID, 0);
        wait_req(t2);
        chk("sample_req period", 64'(t2 - t1), 128);
        wait_rise(0, t1); wait_rise(0, t2);
        chk("bck period", 64'(t2 - t1), 4);
        wait_rise(1, t1); wait_rise(1, t2);
        chk("lrck period", 64'(t2 - t1), 128);
        write(16'hA5C3, 16'h0F0F);
        collect(1, w);
        chk("dac frame A5C3/0F0F", w, 32'hA5C30F0F);
        write(16'h2222, 16'h2222);
        for (int k = 0; k < 200 && (n + 1 - 2*D) % (64*D) != 0; k++) step();
        iDAC_L = 16'h1111; iDAC_R = 16'h1111; iDAC_WE = 1;
        step();
        iDAC_WE = 0;
        chk("coincident write is frame-start", oSAMPLE_REQ, 1);
        collect(0, w);
        chk("coincident frame old shadow", w, 32'h22222222);
        collect(1, w);
        chk("next frame new shadow", w, 32'h11111111);
`ifdef AUDIO_I2S_LOOPBACK_EN
        write(16'hBEEF, 16'h1234);
        wait_req(t1); wait_req(t1);
        chk("loopback valid", oADC_VALID, 1);
        chk("loopback L/R", {oADC_L, oADC_R}, 32'hBEEF1234);
`else
        for (int k = 0; k < 200 && (n + 1 - 2*D) % (64*D) != 0; k++) step();
        nal = 16'h8001; nar = 16'h7FFE;
        wait_req(t1); wait_req(t1);
        chk("adc valid", oADC_VALID, 1);
        chk("adc L/R 8001/7FFE", {oADC_L, oADC_R}, 32'h80017FFE);
`endif
        repeat (10) begin
            nal = 16'($urandom); nar = 16'($urandom);
            repeat ($urandom_range(1, 160)) step();
            write(16'($urandom), 16'($urandom));
        end
        for (int k = 0; k < 300 && !(n > 2*D && (n / (2*D) + 31) % 32 == 20); k++) step();
        iRST_N = 0;
        #1;
        chk("reset immediate", {AUD_BCK, AUD_LRCK, AUD_DACDAT, oSAMPLE_REQ, oADC_VALID, oADC_L, oADC_R}, 0);
        repeat (3) step();
        iRST_N = 1;
        rel = cyc;
        wait_req(t1);
        chk("post-reset frame-start delay", 64'(t1 - rel), 4);
        chk("post-reset no valid", oADC_VALID, 0);
        wait_req(t1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
